// File: rtl/out_fm_ram_to_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// out_fm_ram_to_fifo: streams one output-feature-map tile from RAM into a FIFO,
// zero-filling elements that fall outside the map.                    Rev 1.0
// -----------------------------------------------------------------------------
module out_fm_ram_to_fifo #(
  parameter int CW = 32,
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int Tn = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          ram_rena,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] data_from_ram,
  output logic          fifo_push,
  input  logic          fifo_almost_full,
  output logic [DW-1:0] data_to_fifo,
  input  logic [AW-1:0] tile_base_n,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col
);

  localparam int ROW_STEP = ((Tr + S - K) / S) * S;
  localparam int COL_STEP = ((Tc + S - K) / S) * S;
  localparam int R_STEP   = ((R + S - K) / S) * S;
  localparam int C_STEP   = ((C + S - K) / S) * S;

  localparam logic [CW-1:0] TC_MAX = CW'(COL_STEP - 1);
  localparam logic [CW-1:0] TR_MAX = CW'(ROW_STEP - 1);
  localparam logic [CW-1:0] TN_MAX = CW'(Tn - 1);

  localparam logic [AW:0]   N_LIM     = (AW+1)'(N);
  localparam logic [AW:0]   R_LIM     = (AW+1)'(R_STEP);
  localparam logic [AW:0]   C_LIM     = (AW+1)'(C_STEP);
  localparam logic [AW-1:0] PLANE     = AW'(R_STEP * C_STEP);
  localparam logic [AW-1:0] ROW_PITCH = AW'(C_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tc_q, tc_d, tr_q, tr_d, tn_q, tn_d;
  logic [AW-1:0] base_n_q, base_row_q, base_col_q;
  logic          push_q, legal_q, done_q;
  logic          issue, last_elem, legal, accept;
  logic [AW:0]   n_sum, row_sum, col_sum;
  logic [AW-1:0] elem_addr;

  // Bounds are checked one bit wider so a base near the top of the range cannot wrap into legality.
  assign n_sum   = {1'b0, base_n_q}   + (AW+1)'(tn_q);
  assign row_sum = {1'b0, base_row_q} + (AW+1)'(tr_q);
  assign col_sum = {1'b0, base_col_q} + (AW+1)'(tc_q);
  assign legal   = (n_sum < N_LIM) && (row_sum < R_LIM) && (col_sum < C_LIM);

  assign elem_addr = n_sum[AW-1:0] * PLANE + row_sum[AW-1:0] * ROW_PITCH + col_sum[AW-1:0];
  assign last_elem = (tc_q == TC_MAX) && (tr_q == TR_MAX) && (tn_q == TN_MAX);
  assign accept    = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (!fifo_almost_full) begin
          issue = 1'b1;
          if (last_elem) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (push_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tc_d = tc_q;
    tr_d = tr_q;
    tn_d = tn_q;
    if (accept) begin
      tc_d = '0;
      tr_d = '0;
      tn_d = '0;
    end else if (issue) begin
      if (tc_q == TC_MAX) begin
        tc_d = '0;
        if (tr_q == TR_MAX) begin
          tr_d = '0;
          tn_d = (tn_q == TN_MAX) ? '0 : tn_q + CW'(1);
        end else begin
          tr_d = tr_q + CW'(1);
        end
      end else begin
        tc_d = tc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tc_q       <= '0;
      tr_q       <= '0;
      tn_q       <= '0;
      base_n_q   <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      push_q     <= 1'b0;
      legal_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      tr_q    <= tr_d;
      tn_q    <= tn_d;
      push_q  <= issue;
      legal_q <= issue & legal;
      done_q  <= (state_q == S_DRAIN) && push_q;
      if (accept) begin
        base_n_q   <= tile_base_n;
        base_row_q <= tile_base_row;
        base_col_q <= tile_base_col;
      end
    end
  end

  // Read data lands one cycle after the issue, exactly when its push slot comes up.
  assign ram_rena     = issue & legal;
  assign ram_addr     = ram_rena ? elem_addr : '0;
  assign fifo_push    = push_q;
  assign data_to_fifo = (push_q && legal_q) ? data_from_ram : '0;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_out_fm_ram_to_fifo.sv
`default_nettype none
// Testbench for out_fm_ram_to_fifo: randomized tiles checked against a tile-level reference model.
module tb_out_fm_ram_to_fifo;

  localparam int AW = 16, DW = 32;
  localparam int N = 32, R = 64, C = 32, K = 3, S = 1, TN = 8, TR = 16, TC = 8;
  localparam int ROW_STEP = ((TR + S - K) / S) * S;
  localparam int COL_STEP = ((TC + S - K) / S) * S;
  localparam int R_STEP   = ((R + S - K) / S) * S;
  localparam int C_STEP   = ((C + S - K) / S) * S;
  localparam int TILE     = TN * ROW_STEP * COL_STEP;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, af = 1'b0;
  logic          done, ram_rena, fifo_push;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] bn_in = '0, br_in = '0, bc_in = '0;
  logic [DW-1:0] data_from_ram = '0;
  logic [DW-1:0] data_to_fifo;

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [AW-1:0] addr_log[0:7];
  int push_cnt = 0, rena_cnt = 0, done_cnt = 0;
  int first_push_cyc = 0, last_push_cyc = 0, done_cyc = 0;
  int mode = 0;
  int fifo_cnt = 0;
  bit pend = 1'b0, pop = 1'b0, lat_rena = 1'b0;
  logic [AW-1:0] lat_addr = '0;

  out_fm_ram_to_fifo #(
    .CW(32), .AW(AW), .DW(DW), .N(N), .R(R), .C(C), .K(K), .S(S),
    .Tn(TN), .Tr(TR), .Tc(TC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .done            (done),
    .ram_rena        (ram_rena),
    .ram_addr        (ram_addr),
    .data_from_ram   (data_from_ram),
    .fifo_push       (fifo_push),
    .fifo_almost_full(af),
    .data_to_fifo    (data_to_fifo),
    .tile_base_n     (bn_in),
    .tile_base_row   (br_in),
    .tile_base_col   (bc_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {a ^ 16'h3C5A, ~a};
  endfunction

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // RAM with one-cycle read latency, plus the FIFO/almost_full environment.
  initial begin
    forever begin
      @(negedge clk);
      lat_rena = ram_rena;
      lat_addr = ram_addr;
      @(posedge clk);
      #1;
      data_from_ram = lat_rena ? ram_word(lat_addr) : DW'($urandom);
      if (mode == 1) begin
        pop = (fifo_cnt > 0) && ($urandom_range(0, 1) == 1);
        if (pend) check("fifo_overflow", (fifo_cnt - int'(pop) + 1) > 4, 0);
        fifo_cnt = fifo_cnt - int'(pop) + int'(pend);
        pend = fifo_push;
        af = (fifo_cnt >= 3) || ($urandom_range(0, 1) == 1);
      end else begin
        fifo_cnt = 0;
        pend = 1'b0;
        af = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (ram_rena) begin
      rena_cnt++;
      if (rena_cnt <= 8) addr_log[rena_cnt-1] = ram_addr;
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_addr_unexpected: got %0d, required no read", ram_addr);
      end else begin
        e_addr = exp_addr_q.pop_front();
        check("rd_addr", ram_addr, e_addr);
      end
    end else begin
      check("idle_addr_zero", ram_addr, 0);
    end
    if (fifo_push) begin
      if (push_cnt == 0) first_push_cyc = cyc;
      last_push_cyc = cyc;
      push_cnt++;
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL push_unexpected: got data %0h, required no push", data_to_fifo);
      end else begin
        e_data = exp_data_q.pop_front();
        check("push_data", data_to_fifo, e_data);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_outs_zero();
    check("rst_ram_rena", ram_rena, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_fifo_push", fifo_push, 0);
    check("rst_data_to_fifo", data_to_fifo, 0);
    check("rst_done", done, 0);
  endtask

  task automatic run_tile(input logic [AW-1:0] bn, input logic [AW-1:0] br,
                          input logic [AW-1:0] bc, input bit mid_start, input int abort_at);
    int n, r, c, a, start_cyc, d0, n_legal, pc;
    bit got_done;
    n_legal = 0;
    for (int tn = 0; tn < TN; tn++)
      for (int tr = 0; tr < ROW_STEP; tr++)
        for (int tc = 0; tc < COL_STEP; tc++) begin
          n = int'(bn) + tn;
          r = int'(br) + tr;
          c = int'(bc) + tc;
          if (n < N && r < R_STEP && c < C_STEP) begin
            a = n * R_STEP * C_STEP + r * C_STEP + c;
            exp_addr_q.push_back(AW'(a));
            exp_data_q.push_back(ram_word(AW'(a)));
            n_legal++;
          end else begin
            exp_data_q.push_back('0);
          end
        end
    push_cnt = 0;
    rena_cnt = 0;
    d0 = done_cnt;
    bn_in = bn;
    br_in = br;
    bc_in = bc;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    #2;
    start = 1'b0;
    bn_in = AW'($urandom);
    br_in = AW'($urandom);
    bc_in = AW'($urandom);
    got_done = 1'b0;
    for (int t = 0; t < 6000 && !got_done; t++) begin
      if (abort_at >= 0 && push_cnt >= abort_at) begin
        rst = 1'b0;
        #1;
        check_outs_zero();
        exp_addr_q.delete();
        exp_data_q.delete();
        pc = push_cnt;
        d0 = done_cnt;
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("abort_no_push", push_cnt, pc);
        check("abort_no_done", done_cnt, d0);
        return;
      end
      start = mid_start && (t % 97 == 50);
      @(negedge clk);
      #2;
      got_done = (done_cnt != d0);
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("push_count", push_cnt, TILE);
    check("read_count", rena_cnt, n_legal);
    check("queue_left", exp_data_q.size() + exp_addr_q.size(), 0);
    check("done_after_last_push", done_cyc - last_push_cyc, 1);
    if (mode == 0) begin
      check("first_push_latency", first_push_cyc - start_cyc, 2);
      check("push_burst_span", last_push_cyc - first_push_cyc, TILE - 1);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    #2;
    check("done_single_pulse", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_outs_zero();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("idle_no_push", push_cnt, 0);

    mode = 0;
    run_tile(16'd0, 16'd0, 16'd0, 1'b0, -1);
    check("addr0", addr_log[0], 0);
    check("addr1", addr_log[1], 1);
    check("addr6", addr_log[6], 30);

    run_tile(16'd28, 16'd0, 16'd0, 1'b0, -1);
    check("base_n28_reads", rena_cnt, 336);

    run_tile(16'd0, 16'd0, 16'd26, 1'b0, -1);
    check("base_col26_reads", rena_cnt, 448);
    check("base_col26_addr0", addr_log[0], 26);
    check("base_col26_addr3", addr_log[3], 29);

    run_tile(16'hFFFC, 16'd0, 16'd0, 1'b0, -1);
    check("no_wrap_reads", rena_cnt, 0);

    run_tile(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 61)),
             AW'($urandom_range(0, 29)), 1'b0, -1);

    mode = 1;
    repeat (2) run_tile(AW'($urandom_range(0, 30)), AW'($urandom_range(0, 60)),
                        AW'($urandom_range(0, 28)), 1'b0, -1);
    mode = 0;
    @(negedge clk);
    #2;

    run_tile(16'd4, 16'd8, 16'd12, 1'b1, -1);
    run_tile(16'd0, 16'd0, 16'd0, 1'b0, -1);

    run_tile(16'd0, 16'd0, 16'd0, 1'b0, 100);
    run_tile(16'd2, 16'd3, 16'd4, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/out_fm_ram_to_fifo.md
OUT_FM_RAM_TO_FIFO -- requirements
Module: out_fm_ram_to_fifo

Interface
REQ-001 SHALL have parameter CW, default 32: counter width.
REQ-002 SHALL have parameter AW, default 16: address and tile-base width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameters N=32, R=64, C=32, K=3, S=1: output feature map channels, rows, cols, kernel size, stride.
REQ-005 SHALL have parameters Tn=8, Tr=16, Tc=8: tile channels, rows, cols.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle request to load one tile.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the tile is fully pushed.
REQ-010 SHALL have port ram_rena, output, 1: RAM read enable.
REQ-011 SHALL have port ram_addr, output, AW: RAM read address.
REQ-012 SHALL have port data_from_ram, input, DW: RAM read data, valid one cycle after ram_rena.
REQ-013 SHALL have port fifo_push, output, 1: FIFO write strobe.
REQ-014 SHALL have port fifo_almost_full, input, 1: FIFO has at most one free entry.
REQ-015 SHALL have port data_to_fifo, output, DW: FIFO write data.
REQ-016 SHALL have ports tile_base_n, tile_base_row, tile_base_col, input, AW each: tile origin, sampled on start.

Function
REQ-017 SHALL derive row_step=((Tr+S-K)/S)*S, col_step=((Tc+S-K)/S)*S, R_step=((R+S-K)/S)*S and C_step=((C+S-K)/S)*S; tile size = Tn*row_step*col_step elements.
REQ-018 SHALL implement FSM IDLE -> RUN (start=1) -> DRAIN (last element issued) -> IDLE (last push done); done=1 on the DRAIN->IDLE transition cycle only.
REQ-019 SHALL ignore start in RUN and DRAIN; start in IDLE latches the three tile bases and clears counters tc, tr, tn.
REQ-020 SHALL issue one element per cycle in RUN when fifo_almost_full=0, and issue nothing while fifo_almost_full=1.
REQ-021 SHALL order elements tc fastest (0..col_step-1), then tr (0..row_step-1), then tn (0..Tn-1), wrapping inner counters at max.
REQ-022 SHALL treat an element as legal iff base_n+tn<N, base_row+tr<R_step, base_col+tc<C_step, all compared in AW+1 bits (no wrap).
REQ-023 SHALL, for a legal element, assert ram_rena with ram_addr=(base_n+tn)*R_step*C_step+(base_row+tr)*C_step+base_col+tc, truncated to AW bits.
REQ-024 SHALL, for an illegal element, keep ram_rena=0 and push zero in the same slot.
REQ-025 SHALL assert fifo_push exactly one cycle after each issue, regardless of fifo_almost_full at that cycle; data_to_fifo = data_from_ram (legal) or 0 (illegal).
REQ-026 SHALL push exactly Tn*row_step*col_step entries per start, never more, never fewer.
REQ-027 SHALL guarantee no push into a full FIFO, given at most one push per cycle and issue gated by fifo_almost_full.
REQ-028 SHALL drive ram_addr=0 whenever ram_rena=0.
REQ-029 SHALL accept start in the cycle after done, with no lost cycle.

Reset
REQ-030 SHALL, while rst=0, force FSM=IDLE, counters=0, ram_rena=0, ram_addr=0, fifo_push=0, data_to_fifo=0, done=0 and latched bases=0.
REQ-031 SHALL abort any in-flight tile on reset mid-operation: no push, no done after release; the next start begins a fresh tile.

Verification
REQ-032 Defaults, bases 0, almost_full=0, start -> 672 pushes on consecutive cycles, first push 2 cycles after start, done 1 cycle after the last push, first ram_addr=0, second 1, seventh 30.
REQ-033 Defaults, base_n=28 -> tn 4..7 illegal: elements 336..671 have ram_rena=0, pushed value 0, still 672 pushes.
REQ-034 Defaults, base_col=26 -> tc 4,5 pushed as 0 in every row; tc 0..3 read addresses 26..29.
REQ-035 Toggle almost_full randomly (50%), FIFO model depth 4 -> no overflow, order and data match golden model, 672 pushes.
REQ-036 rst=0 at element 100 -> outputs zero immediately; after release, no push and no done until the next start, which yields 672 pushes.
REQ-037 start pulses during RUN and back-to-back start after done -> mid-run starts ignored; the back-to-back tile starts on time.
